// File: rtl/fft_pingpong_sram.sv
// Ping-pong complex sample buffer: two banks of DEPTH {re,im} words, dual write/read ports,
// bank swap per stage, in-place mode and a built-in bank clear engine.
module fft_pingpong_sram #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inplace,
  input  logic          swap,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr1,
  input  logic [AW-1:0] wr_addr2,
  input  logic [DW-1:0] wr_re1,
  input  logic [DW-1:0] wr_im1,
  input  logic [DW-1:0] wr_re2,
  input  logic [DW-1:0] wr_im2,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  output logic [DW-1:0] rd_re1,
  output logic [DW-1:0] rd_im1,
  output logic [DW-1:0] rd_re2,
  output logic [DW-1:0] rd_im2,
  output logic          rd_valid,
  input  logic          clr_start,
  output logic          busy,
  output logic          clr_done,
  output logic          bank_sel
);

  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLR,
    S_DONE
  } state_e;

  state_e          state_q;
  logic [AW-2:0]   cnt_q;
  logic            clr_bank_q;
  logic            bank_sel_q;
  logic            busy_q;
  logic            clr_done_q;

  logic [2*DW-1:0] mem_q [2][DEPTH];

  logic [DW-1:0]   rd_re1_q, rd_im1_q, rd_re2_q, rd_im2_q;
  logic            rd_valid_q;

  logic            wr_bank_d;

  always_comb begin
    wr_bank_d = inplace ? bank_sel_q : ~bank_sel_q;
  end

  // Clear FSM and bank select; busy/clr_done are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      clr_bank_q <= 1'b0;
      bank_sel_q <= 1'b0;
      busy_q     <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      if (swap && !busy_q) begin
        bank_sel_q <= ~bank_sel_q;
      end
      case (state_q)
        S_IDLE: begin
          if (clr_start) begin
            state_q    <= S_CLR;
            cnt_q      <= '0;
            clr_bank_q <= wr_bank_d;
            busy_q     <= 1'b1;
          end
        end
        S_CLR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == '1) begin
            state_q    <= S_DONE;
            clr_done_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q    <= S_IDLE;
          busy_q     <= 1'b0;
          clr_done_q <= 1'b0;
        end
        default: begin
          state_q    <= S_IDLE;
          busy_q     <= 1'b0;
          clr_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Port 2 is written after port 1 so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (state_q == S_CLR) begin
      mem_q[clr_bank_q][{cnt_q, 1'b0}] <= '0;
      mem_q[clr_bank_q][{cnt_q, 1'b1}] <= '0;
    end else if (wr_en && !busy_q) begin
      mem_q[wr_bank_d][wr_addr1] <= {wr_re1, wr_im1};
      mem_q[wr_bank_d][wr_addr2] <= {wr_re2, wr_im2};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_re1_q   <= '0;
      rd_im1_q   <= '0;
      rd_re2_q   <= '0;
      rd_im2_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        {rd_re1_q, rd_im1_q} <= mem_q[bank_sel_q][rd_addr1];
        {rd_re2_q, rd_im2_q} <= mem_q[bank_sel_q][rd_addr2];
      end
    end
  end

  assign rd_re1   = rd_re1_q;
  assign rd_im1   = rd_im1_q;
  assign rd_re2   = rd_re2_q;
  assign rd_im2   = rd_im2_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign clr_done = clr_done_q;
  assign bank_sel = bank_sel_q;

endmodule

// File: tb/tb_fft_pingpong_sram.sv
// Directed bench for fft_pingpong_sram: default geometry plus a DW=24/AW=4 instance.
module tb_fft_pingpong_sram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inplace, swap, wr_en, rd_en, clr_start;
  logic [8:0]  wr_addr1, wr_addr2, rd_addr1, rd_addr2;
  logic [15:0] wr_re1, wr_im1, wr_re2, wr_im2;
  logic [15:0] rd_re1, rd_im1, rd_re2, rd_im2;
  logic        rd_valid, busy, clr_done, bank_sel;

  logic        s_inplace, s_swap, s_wr_en, s_rd_en, s_clr_start;
  logic [3:0]  s_wr_addr1, s_wr_addr2, s_rd_addr1, s_rd_addr2;
  logic [23:0] s_wr_re1, s_wr_im1, s_wr_re2, s_wr_im2;
  logic [23:0] s_rd_re1, s_rd_im1, s_rd_re2, s_rd_im2;
  logic        s_rd_valid, s_busy, s_clr_done, s_bank_sel;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fft_pingpong_sram u_dut (
    .clk(clk), .rst_n(rst_n), .inplace(inplace), .swap(swap), .wr_en(wr_en),
    .wr_addr1(wr_addr1), .wr_addr2(wr_addr2), .wr_re1(wr_re1), .wr_im1(wr_im1),
    .wr_re2(wr_re2), .wr_im2(wr_im2), .rd_en(rd_en), .rd_addr1(rd_addr1),
    .rd_addr2(rd_addr2), .rd_re1(rd_re1), .rd_im1(rd_im1), .rd_re2(rd_re2),
    .rd_im2(rd_im2), .rd_valid(rd_valid), .clr_start(clr_start), .busy(busy),
    .clr_done(clr_done), .bank_sel(bank_sel)
  );

  fft_pingpong_sram #(.DW(24), .AW(4)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .inplace(s_inplace), .swap(s_swap), .wr_en(s_wr_en),
    .wr_addr1(s_wr_addr1), .wr_addr2(s_wr_addr2), .wr_re1(s_wr_re1), .wr_im1(s_wr_im1),
    .wr_re2(s_wr_re2), .wr_im2(s_wr_im2), .rd_en(s_rd_en), .rd_addr1(s_rd_addr1),
    .rd_addr2(s_rd_addr2), .rd_re1(s_rd_re1), .rd_im1(s_rd_im1), .rd_re2(s_rd_re2),
    .rd_im2(s_rd_im2), .rd_valid(s_rd_valid), .clr_start(s_clr_start), .busy(s_busy),
    .clr_done(s_clr_done), .bank_sel(s_bank_sel)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    swap = 0; wr_en = 0; rd_en = 0; clr_start = 0;
    s_swap = 0; s_wr_en = 0; s_rd_en = 0; s_clr_start = 0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n;
    int          dones;
    logic [63:0] acc;
    logic        bad;

    rst_n = 0; inplace = 0; s_inplace = 0;
    idle();
    wr_addr1 = '0; wr_addr2 = '0; rd_addr1 = '0; rd_addr2 = '0;
    wr_re1 = '0; wr_im1 = '0; wr_re2 = '0; wr_im2 = '0;
    s_wr_addr1 = '0; s_wr_addr2 = '0; s_rd_addr1 = '0; s_rd_addr2 = '0;
    s_wr_re1 = '0; s_wr_im1 = '0; s_wr_re2 = '0; s_wr_im2 = '0;
    repeat (2) tick();
    check("rst_rd_re1", rd_re1, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_clr_done", clr_done, 0);
    check("rst_bank_sel", bank_sel, 0);
    rst_n = 1;
    tick();

    // Ping-pong: write bank 1 with swap in the same cycle, then read it.
    wr_en = 1; swap = 1;
    wr_addr1 = 3; wr_re1 = 16'h1234; wr_im1 = 16'h5678;
    wr_addr2 = 4; wr_re2 = 16'h9ABC; wr_im2 = 16'hDEF0;
    tick(); idle();
    check("pp_bank_sel", bank_sel, 1);
    check("pp_valid_idle", rd_valid, 0);
    rd_en = 1; rd_addr1 = 3; rd_addr2 = 4;
    tick(); idle();
    check("pp_re1", rd_re1, 16'h1234);
    check("pp_im1", rd_im1, 16'h5678);
    check("pp_re2", rd_re2, 16'h9ABC);
    check("pp_im2", rd_im2, 16'hDEF0);
    check("pp_valid", rd_valid, 1);
    tick();
    check("pp_valid_drop", rd_valid, 0);
    check("pp_hold", rd_re1, 16'h1234);

    // Collision at address 7 into bank 0.
    wr_en = 1; wr_addr1 = 7; wr_addr2 = 7;
    wr_re1 = 16'h1111; wr_im1 = 16'h1111; wr_re2 = 16'h2222; wr_im2 = 16'h2222;
    tick(); idle();
    swap = 1;
    tick(); idle();
    check("col_bank_sel", bank_sel, 0);
    rd_en = 1; rd_addr1 = 7; rd_addr2 = 7;
    tick(); idle();
    check("col_re1", rd_re1, 16'h2222);
    check("col_im2", rd_im2, 16'h2222);

    // In-place read-during-write returns old data.
    inplace = 1;
    wr_en = 1; wr_addr1 = 5; wr_re1 = 16'h0A0A; wr_im1 = 16'h0B0B;
    wr_addr2 = 6; wr_re2 = 16'h0E0E; wr_im2 = 16'h0F0F;
    tick(); idle();
    wr_en = 1; wr_addr1 = 5; wr_re1 = 16'h0C0C; wr_im1 = 16'h0D0D;
    rd_en = 1; rd_addr1 = 5; rd_addr2 = 6;
    tick(); idle();
    check("rdw_old_re", rd_re1, 16'h0A0A);
    check("rdw_old_im", rd_im1, 16'h0B0B);
    check("rdw_port2", rd_re2, 16'h0E0E);
    rd_en = 1; rd_addr1 = 5;
    tick(); idle();
    check("rdw_new_re", rd_re1, 16'h0C0C);
    check("rdw_new_im", rd_im1, 16'h0D0D);

    // Fill bank 1 and clear it while hammering ignored inputs.
    inplace = 0;
    for (int k = 0; k < 256; k++) begin
      wr_en = 1;
      wr_addr1 = 9'(2 * k);     wr_re1 = 16'(k + 1); wr_im1 = 16'hA5A5;
      wr_addr2 = 9'(2 * k + 1); wr_re2 = 16'(k + 2); wr_im2 = 16'h5A5A;
      tick();
    end
    idle();
    clr_start = 1;
    tick(); idle();
    check("clr_busy_start", busy, 1);
    n = 0; dones = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      if (clr_done === 1'b1) dones++;
      wr_en = 1; wr_addr1 = 0; wr_addr2 = 1;
      wr_re1 = 16'hDEAD; wr_im1 = 16'hBEEF; wr_re2 = 16'hDEAD; wr_im2 = 16'hBEEF;
      swap = 1; clr_start = 1;
      tick();
    end
    idle();
    check("clr_busy_cycles", n, 257);
    check("clr_done_pulses", dones, 1);
    check("clr_swap_ignored", bank_sel, 0);
    swap = 1;
    tick(); idle();
    acc = '0;
    for (int k = 0; k < 256; k++) begin
      rd_en = 1; rd_addr1 = 9'(2 * k); rd_addr2 = 9'(2 * k + 1);
      tick();
      acc = acc | {rd_re1, rd_im1, rd_re2, rd_im2};
    end
    idle();
    check("clr_bank1_zero", acc, 0);
    swap = 1;
    tick(); idle();
    rd_en = 1; rd_addr1 = 5; rd_addr2 = 7;
    tick(); idle();
    check("clr_bank0_5", {rd_re1, rd_im1}, 32'h0C0C0D0D);
    check("clr_bank0_7", {rd_re2, rd_im2}, 32'h22222222);

    // Reset mid-clear after 10 clear cycles.
    for (int k = 0; k < 20; k++) begin
      wr_en = 1;
      wr_addr1 = 9'(2 * k);     wr_re1 = 16'(k + 16'h100); wr_im1 = 16'h7777;
      wr_addr2 = 9'(2 * k + 1); wr_re2 = 16'(k + 16'h200); wr_im2 = 16'h8888;
      tick();
    end
    idle();
    rd_en = 1; rd_addr1 = 7; rd_addr2 = 7;
    tick(); idle();
    clr_start = 1;
    tick(); idle();
    repeat (10) tick();
    check("mid_busy_before", busy, 1);
    rst_n = 0;
    #1;
    check("mid_busy", busy, 0);
    check("mid_rd_re1", rd_re1, 0);
    check("mid_rd_im2", rd_im2, 0);
    check("mid_clr_done", clr_done, 0);
    tick();
    rst_n = 1;
    tick();
    check("mid_idle", busy, 0);
    swap = 1;
    tick(); idle();
    bad = 1'b0; acc = '0;
    for (int k = 0; k < 20; k++) begin
      rd_en = 1; rd_addr1 = 9'(2 * k); rd_addr2 = 9'(2 * k + 1);
      tick();
      if (k < 10) begin
        acc = acc | {rd_re1, rd_im1, rd_re2, rd_im2};
      end else if ({rd_re1, rd_im1, rd_re2, rd_im2} !==
                   {16'(k + 16'h100), 16'h7777, 16'(k + 16'h200), 16'h8888}) begin
        bad = 1'b1;
      end
    end
    idle();
    check("mid_zero_0_19", acc, 0);
    check("mid_kept_20_39", bad, 0);

    // DW=24 / AW=4 instance.
    s_wr_en = 1; s_swap = 1;
    s_wr_addr1 = 3;  s_wr_re1 = 24'hABCDEF; s_wr_im1 = 24'h123456;
    s_wr_addr2 = 15; s_wr_re2 = 24'hFFFFFF; s_wr_im2 = 24'h000001;
    tick(); idle();
    check("sw_bank_sel", s_bank_sel, 1);
    s_rd_en = 1; s_rd_addr1 = 3; s_rd_addr2 = 15;
    tick(); idle();
    check("sw_rd1", {s_rd_re1, s_rd_im1}, 48'hABCDEF123456);
    check("sw_rd2", {s_rd_re2, s_rd_im2}, 48'hFFFFFF000001);
    check("sw_valid", s_rd_valid, 1);
    s_wr_en = 1; s_wr_addr1 = 2; s_wr_addr2 = 9;
    s_wr_re1 = 24'h111111; s_wr_im1 = 24'h222222; s_wr_re2 = 24'h333333; s_wr_im2 = 24'h444444;
    tick(); idle();
    s_clr_start = 1;
    tick(); idle();
    n = 0; dones = 0;
    while (s_busy === 1'b1 && n < 100) begin
      if (s_clr_done !== 1'b1) n++;
      else dones++;
      tick();
    end
    check("sw_clr_cycles", n, 8);
    check("sw_clr_done", dones, 1);
    s_swap = 1;
    tick(); idle();
    s_rd_en = 1; s_rd_addr1 = 2; s_rd_addr2 = 9;
    tick(); idle();
    check("sw_clr_zero", {s_rd_re1, s_rd_im1, s_rd_re2, s_rd_im2}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
